execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Third stage of the 5-stage RISC-V pipeline; consumes the ID/EX register outputs of the decode stage.
- Selects forwarded operands, runs the ALU and resolves branches, then registers results into the EX/MEM pipeline register for the memory stage.
- Branch decision and target go back to fetch combinationally in the same cycle.

Parameters:
- XLEN, 32, datapath width of operands, immediates, PC and results.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- RegWriteE  input  1  register write enable for the instruction in EX
- ALUSrcE  input  1  0 = SrcB from forwarded RD2, 1 = SrcB from Imm_Ext_E
- MemWriteE  input  1  store enable
- ResultSrcE  input  1  0 = writeback ALU result, 1 = writeback memory data
- BranchE  input  1  instruction is a beq
- ALUControlE  input  3  ALU operation select
- RD1_E  input  XLEN  rs1 value read in decode
- RD2_E  input  XLEN  rs2 value read in decode
- Imm_Ext_E  input  XLEN  sign-extended immediate
- RD_E  input  5  destination register
- PCE  input  XLEN  PC of the instruction in EX
- PCPlus4E  input  XLEN  PC+4 of the instruction in EX
- ResultW  input  XLEN  writeback-stage result, forwarding source
- ForwardA_E  input  2  SrcA select from hazard unit
- ForwardB_E  input  2  rs2 select from hazard unit
- PCSrcE  output  1  branch taken, redirect fetch (combinational)
- PCTargetE  output  XLEN  branch target PCE + Imm_Ext_E (combinational)
- RegWriteM  output  1  registered RegWriteE
- MemWriteM  output  1  registered MemWriteE
- ResultSrcM  output  1  registered ResultSrcE
- RD_M  output  5  registered RD_E
- PCPlus4M  output  XLEN  registered PCPlus4E
- WriteDataM  output  XLEN  registered forwarded rs2 value (store data)
- ALU_ResultM  output  XLEN  registered ALU result

Behaviour:
- Forward mux encoding, same for A and B:
  - 00 selects RD1_E or RD2_E.
  - 01 selects ResultW.
  - 10 selects the current ALU_ResultM register (M-stage feedback, taken internally).
  - 11 is reserved and selects the register-file value.
- SrcA = forwarded A. SrcB = Imm_Ext_E when ALUSrcE = 1, else forwarded B. Store data is always forwarded B, regardless of ALUSrcE.
- ALUControlE encoding:
  - 000 add, modulo 2^XLEN, carry discarded.
  - 001 sub, modulo 2^XLEN.
  - 010 and.
  - 011 or.
  - 101 slt: signed two's-complement compare, result 1 or 0, zero-extended.
  - Any other code gives result 0.
- Zero = 1 when the ALU result equals 0.
- PCSrcE = BranchE & Zero. PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN, wrap-around ignored. Both are purely combinational and are valid in the same cycle as the inputs.
- EX/MEM register:
  - On every rising clk with rst high, all M outputs load their E-side values.
  - Latency is 1 cycle, throughput 1 instruction per cycle.
  - There is no stall or enable: the register updates every cycle.
- Reset:
  - rst low clears RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM and ALU_ResultM to 0 immediately, independent of clk.
  - Reset asserted mid-operation discards the in-flight instruction. No spurious write is issued because RegWriteM and MemWriteM are 0.
  - The first edge after rst deasserts loads normal values.
  - PCSrcE and PCTargetE are not reset; they follow their inputs.
- M-stage forwarding uses the register value before the current edge. A chain of dependent instructions therefore forwards the previous instruction's result correctly.
- Simultaneous ForwardA_E = 10 and ForwardB_E = 01 is legal. Each mux selects independently.
- RD_M = 0 with RegWriteM = 1 is passed through unchanged. Suppressing writes to x0 belongs to the register file.

Test Plan:
- Reset: hold rst low with random inputs, toggle clk → all M outputs stay 0. Release rst with ALUControlE=000, RD1_E=5, RD2_E=7, ALUSrcE=0 → ALU_ResultM=12 after one edge.
- ALU ops: RD1_E=0xFFFFFFFF, RD2_E=1.
  - add → ALU_ResultM=0.
  - sub → 0xFFFFFFFE.
  - slt → 1 (signed −1 < 1).
  - Code 111 → 0.
- Immediate and store data: ALUSrcE=1, RD1_E=0x100, Imm_Ext_E=0xFFFFFFFC, RD2_E=0xAB, MemWriteE=1 → ALU_ResultM=0xFC, WriteDataM=0xAB, MemWriteM=1.
- Forwarding:
  - Cycle 1: add 3+4 → ALU_ResultM=7.
  - Cycle 2: ForwardA_E=10, ForwardB_E=01, ResultW=10, sub → ALU_ResultM = 7 − 10 = 0xFFFFFFFD.
- Branch: BranchE=1, sub, RD1_E=RD2_E=9, PCE=0x40, Imm_Ext_E=0xFFFFFFF8 → same cycle PCSrcE=1, PCTargetE=0x38. With RD2_E=8 → PCSrcE=0.
- Mid-operation reset: assert rst asynchronously between edges while RegWriteM=1 and ALU_ResultM=0x55 → both drop to 0 immediately, before the next edge.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RISC-V pipeline: operand forwarding, ALU, beq
// resolution, and the EX/MEM pipeline register feeding the memory stage.
module execute_cycle #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteE,
   input  logic            ALUSrcE,
   input  logic            MemWriteE,
   input  logic            ResultSrcE,
   input  logic            BranchE,
   input  logic [2:0]      ALUControlE,
   input  logic [XLEN-1:0] RD1_E,
   input  logic [XLEN-1:0] RD2_E,
   input  logic [XLEN-1:0] Imm_Ext_E,
   input  logic [4:0]      RD_E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [XLEN-1:0] ResultW,
   input  logic [1:0]      ForwardA_E,
   input  logic [1:0]      ForwardB_E,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic            ResultSrcM,
   output logic [4:0]      RD_M,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] ALU_ResultM
);

   logic [XLEN-1:0] w_src_a;
   logic [XLEN-1:0] w_fwd_b;
   logic [XLEN-1:0] w_src_b;
   logic [XLEN-1:0] w_alu_result;
   logic            w_zero;

   logic            r_reg_write_m;
   logic            r_mem_write_m;
   logic            r_result_src_m;
   logic [4:0]      r_rd_m;
   logic [XLEN-1:0] r_pc_plus4_m;
   logic [XLEN-1:0] r_write_data_m;
   logic [XLEN-1:0] r_alu_result_m;

   // Code 10 feeds back the EX/MEM result from the previous instruction;
   // the reserved code 11 falls back to the register-file value.
   always_comb begin
      w_src_a = RD1_E;
      case (ForwardA_E)
         2'b01:   w_src_a = ResultW;
         2'b10:   w_src_a = r_alu_result_m;
         default: w_src_a = RD1_E;
      endcase
   end

   always_comb begin
      w_fwd_b = RD2_E;
      case (ForwardB_E)
         2'b01:   w_fwd_b = ResultW;
         2'b10:   w_fwd_b = r_alu_result_m;
         default: w_fwd_b = RD2_E;
      endcase
   end

   assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

   always_comb begin
      w_alu_result = '0;
      case (ALUControlE)
         3'b000:  w_alu_result = w_src_a + w_src_b;
         3'b001:  w_alu_result = w_src_a - w_src_b;
         3'b010:  w_alu_result = w_src_a & w_src_b;
         3'b011:  w_alu_result = w_src_a | w_src_b;
         3'b101:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
         default: w_alu_result = '0;
      endcase
   end

   assign w_zero    = (w_alu_result == '0);
   assign PCSrcE    = BranchE & w_zero;
   assign PCTargetE = PCE + Imm_Ext_E;

   // Clearing the write enables on reset keeps a discarded instruction from
   // reaching memory or the register file.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reg_write_m  <= 1'b0;
         r_mem_write_m  <= 1'b0;
         r_result_src_m <= 1'b0;
         r_rd_m         <= '0;
         r_pc_plus4_m   <= '0;
         r_write_data_m <= '0;
         r_alu_result_m <= '0;
      end else begin
         r_reg_write_m  <= RegWriteE;
         r_mem_write_m  <= MemWriteE;
         r_result_src_m <= ResultSrcE;
         r_rd_m         <= RD_E;
         r_pc_plus4_m   <= PCPlus4E;
         r_write_data_m <= w_fwd_b;
         r_alu_result_m <= w_alu_result;
      end
   end

   assign RegWriteM   = r_reg_write_m;
   assign MemWriteM   = r_mem_write_m;
   assign ResultSrcM  = r_result_src_m;
   assign RD_M        = r_rd_m;
   assign PCPlus4M    = r_pc_plus4_m;
   assign WriteDataM  = r_write_data_m;
   assign ALU_ResultM = r_alu_result_m;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: expected EX/MEM contents are queued when
// a vector is driven and compared one edge later.
module tb_execute_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

   typedef struct packed {
      logic        rw;
      logic        mw;
      logic        rs;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic [31:0] wd;
      logic [31:0] alu;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_alu;
   int          n_vec = 0;
   int          n_err = 0;

   execute_cycle #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
      .ALU_ResultM(ALU_ResultM)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] fwd_model(input logic [1:0] sel, input logic [31:0] rf);
      if (sel == 2'b01) return ResultW;
      if (sel == 2'b10) return m_alu;
      return rf;
   endfunction

   task automatic clr_inputs();
      RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
      ALUControlE = 3'd0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
      PCE = 0; PCPlus4E = 0; ResultW = 0; ForwardA_E = 0; ForwardB_E = 0;
   endtask

   task automatic rand_inputs();
      RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
      ResultSrcE = 1'($urandom); BranchE = 1'($urandom);
      ALUControlE = 3'($urandom); RD1_E = $urandom; RD2_E = $urandom;
      Imm_Ext_E = $urandom; RD_E = 5'($urandom); PCE = $urandom;
      PCPlus4E = $urandom; ResultW = $urandom;
      ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
   endtask

   // Inputs are already set; check combinational branch outputs, queue the
   // expected M-stage contents, clock once and compare.
   task automatic step(input string tag);
      exp_t        e, g;
      logic [31:0] a, fb, b, r;
      a  = fwd_model(ForwardA_E, RD1_E);
      fb = fwd_model(ForwardB_E, RD2_E);
      b  = ALUSrcE ? Imm_Ext_E : fb;
      r  = alu_model(ALUControlE, a, b);
      #1;
      chk({tag, ".pcsrc"}, {31'd0, PCSrcE}, {31'd0, BranchE & (r == 32'd0)});
      chk({tag, ".pctgt"}, PCTargetE, PCE + Imm_Ext_E);
      e = '{rw: RegWriteE, mw: MemWriteE, rs: ResultSrcE, rd: RD_E,
            pc4: PCPlus4E, wd: fb, alu: r};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      m_alu = r;
      g = sb_q.pop_front();
      chk({tag, ".alu"},  ALU_ResultM, g.alu);
      chk({tag, ".wd"},   WriteDataM, g.wd);
      chk({tag, ".pc4"},  PCPlus4M, g.pc4);
      chk({tag, ".ctl"},  {24'd0, RegWriteM, MemWriteM, ResultSrcM, RD_M},
                          {24'd0, g.rw, g.mw, g.rs, g.rd});
      $display("txn %-10s alu=%h wd=%h rd=%0d rw=%b mw=%b pcsrc=%b tgt=%h",
               tag, ALU_ResultM, WriteDataM, RD_M, RegWriteM, MemWriteM, PCSrcE, PCTargetE);
   endtask

   task automatic chk_m_zero(input string tag);
      chk({tag, ".alu"}, ALU_ResultM, 32'd0);
      chk({tag, ".wd"},  WriteDataM, 32'd0);
      chk({tag, ".pc4"}, PCPlus4M, 32'd0);
      chk({tag, ".ctl"}, {24'd0, RegWriteM, MemWriteM, ResultSrcM, RD_M}, 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      m_alu = 32'd0;
      for (int i = 0; i < 4; i++) begin
         rand_inputs();
         @(posedge clk);
         #1;
         chk_m_zero("rst_hold");
         $display("txn rst_hold   cycle %0d outputs held at zero", i);
      end
      #2 rst = 1'b1;

      clr_inputs();
      RD1_E = 32'd5; RD2_E = 32'd7;
      step("rst_rel");
      chk("rst_rel.lit", ALU_ResultM, 32'd12);

      clr_inputs();
      RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
      ALUControlE = 3'b000; step("add");   chk("add.lit", ALU_ResultM, 32'd0);
      ALUControlE = 3'b001; step("sub");   chk("sub.lit", ALU_ResultM, 32'hFFFF_FFFE);
      ALUControlE = 3'b101; step("slt");   chk("slt.lit", ALU_ResultM, 32'd1);
      ALUControlE = 3'b111; step("op111"); chk("op111.lit", ALU_ResultM, 32'd0);

      clr_inputs();
      ALUSrcE = 1; RD1_E = 32'h100; Imm_Ext_E = 32'hFFFF_FFFC; RD2_E = 32'hAB; MemWriteE = 1;
      step("imm_st");
      chk("imm_st.lit", ALU_ResultM, 32'hFC);
      chk("imm_st.wdl", WriteDataM, 32'hAB);
      chk("imm_st.mw", {31'd0, MemWriteM}, 32'd1);

      clr_inputs();
      RD1_E = 32'd3; RD2_E = 32'd4; RegWriteE = 1;
      step("fwd1");
      chk("fwd1.lit", ALU_ResultM, 32'd7);
      RD1_E = 32'h1111; RD2_E = 32'h2222; ALUControlE = 3'b001;
      ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = 32'd10;
      step("fwd2");
      chk("fwd2.lit", ALU_ResultM, 32'hFFFF_FFFD);
      chk("fwd2.wdl", WriteDataM, 32'd10);

      clr_inputs();
      BranchE = 1; ALUControlE = 3'b001; RD1_E = 32'd9; RD2_E = 32'd9;
      PCE = 32'h40; Imm_Ext_E = 32'hFFFF_FFF8;
      step("br_take");
      chk("br_take.src", {31'd0, PCSrcE}, 32'd1);
      chk("br_take.tgt", PCTargetE, 32'h38);
      RD2_E = 32'd8;
      step("br_not");
      chk("br_not.src", {31'd0, PCSrcE}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         rand_inputs();
         step("rand");
      end

      clr_inputs();
      RegWriteE = 1; MemWriteE = 1; RD1_E = 32'h50; RD2_E = 32'h5; RD_E = 5'd3;
      step("pre_rst");
      chk("pre_rst.lit", ALU_ResultM, 32'h55);
      #2 rst = 1'b0;
      #1;
      chk_m_zero("mid_rst");
      $display("txn mid_rst    outputs cleared before next edge");
      m_alu = 32'd0;
      @(posedge clk);
      #2 rst = 1'b1;

      clr_inputs();
      RegWriteE = 1; RD_E = 5'd0; RD1_E = 32'd1; RD2_E = 32'd2; ForwardA_E = 2'b10;
      step("x0_pass");
      chk("x0_pass.lit", ALU_ResultM, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
